// File: rtl/sram_arbiter_rr.sv
// rtl/sram_arbiter_rr.sv - N-port arbiter in front of an asynchronous SRAM, one access per 3-cycle slot
// Define SRAM_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration instead of round-robin.
module sram_arbiter_rr #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int N_PORTS = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          req_valid,
    input  logic [N_PORTS-1:0]          req_we,
    input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [N_PORTS*DATA_W/8-1:0] req_be,
    output logic [N_PORTS-1:0]          req_ready,
    output logic [N_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [ADDR_W-1:0]           SRAM_ADDR,
    inout  wire  [DATA_W-1:0]           SRAM_DQ,
    output logic                        SRAM_WE_N,
    output logic                        SRAM_OE_N,
    output logic                        SRAM_CE_N,
    output logic                        SRAM_UB_N,
    output logic                        SRAM_LB_N
);
    localparam int BE_W = DATA_W / 8;
    localparam int PW   = $clog2(N_PORTS);

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
    state_t state, state_nxt;

    logic              grant_any;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     cand;
    logic [PW-1:0]     owner;
    logic              transfer;
    logic              lat_we;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [BE_W-1:0]   be_sel;
    logic              we_sel;
    logic              lb_en;
    logic              ub_en;
    logic              dq_oe;
    logic [DATA_W-1:0] dq_out;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
    logic [PW-1:0]     last_grant;
`endif

    // Search order starts one past the previous winner so every port gets a turn.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
            cand = PW'(k);
`else
            cand = PW'((int'(last_grant) + k + 1) % N_PORTS);
`endif
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        addr_sel  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        wdata_sel = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
        be_sel    = req_be[int'(grant_idx)*BE_W +: BE_W];
        we_sel    = req_we[grant_idx];
        lb_en     = be_sel[0];
        ub_en     = (BE_W > 1) ? be_sel[(BE_W > 1) ? 1 : 0] : 1'b0;
        req_ready = '0;
        if (state == IDLE && !reset && grant_any)
            req_ready = N_PORTS'(1) << grant_idx;
        transfer  = |(req_valid & req_ready);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (transfer) state_nxt = ACCESS;
            ACCESS:  state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // SRAM pins are registered so they only move on the clock edge; the pin
    // registers double as the latched request (address, data, byte enables).
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_CE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            owner     <= '0;
            lat_we    <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
            last_grant <= PW'(N_PORTS - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= '0;
                    if (transfer) begin
                        SRAM_ADDR <= addr_sel;
                        SRAM_CE_N <= 1'b0;
                        // An all-zero byte mask still uses the slot but never strobes WE.
                        SRAM_WE_N <= ~(we_sel & (|be_sel));
                        SRAM_OE_N <= we_sel;
                        SRAM_LB_N <= ~lb_en;
                        SRAM_UB_N <= ~ub_en;
                        dq_oe     <= we_sel;
                        dq_out    <= wdata_sel;
                        owner     <= grant_idx;
                        lat_we    <= we_sel;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
                        last_grant <= grant_idx;
`endif
                    end
                end
                ACCESS: begin
                    SRAM_WE_N <= 1'b1;
                    SRAM_OE_N <= 1'b1;
                    if (!lat_we) begin
                        rsp_rdata <= SRAM_DQ;
                        rsp_valid <= N_PORTS'(1) << owner;
                    end else begin
                        rsp_valid <= '0;
                    end
                end
                RECOVER: begin
                    rsp_valid <= '0;
                    SRAM_CE_N <= 1'b1;
                    SRAM_UB_N <= 1'b1;
                    SRAM_LB_N <= 1'b1;
                    dq_oe     <= 1'b0;
                end
                default: rsp_valid <= '0;
            endcase
        end
    end

    assign SRAM_DQ = dq_oe ? dq_out : {DATA_W{1'bz}};

endmodule

// File: doc/sram_arbiter_rr.md
SRAM_ARBITER_RR -- requirements
Module: sram_arbiter_rr

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 The block SHALL provide parameter DATA_W, default 16, SRAM data width; multiple of 8.
REQ-003 The block SHALL provide parameter N_PORTS, default 4, number of requesters (2..8).
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, with ports as follows:
- CLOCK_50  in  1  single clock, all logic on its rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  N_PORTS  per-port request valid
- req_we  in  N_PORTS  per-port 1=write, 0=read
- req_addr  in  N_PORTS*ADDR_W  packed; port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_PORTS*DATA_W  packed write data
- req_be  in  N_PORTS*DATA_W/8  packed byte enables, active-high
- req_ready  out  N_PORTS  one-hot grant/accept
- rsp_valid  out  N_PORTS  one-cycle read-data pulse for the owning port
- rsp_rdata  out  DATA_W  read data, shared by all ports
- SRAM_ADDR  out  ADDR_W
- SRAM_DQ  inout  DATA_W
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N  out  1 each  active-low strobes
- SRAM_UB_N, SRAM_LB_N  out  1 each  active-low byte lanes; valid only when DATA_W=16

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS and RECOVER, with transitions IDLE->ACCESS on any req_valid, ACCESS->RECOVER always, and RECOVER->IDLE always.
REQ-006 In IDLE, req_ready SHALL be combinational and high for exactly the arbitration winner while req_valid is high for that port; in all other states it SHALL be all-zero.
REQ-007 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; the block SHALL latch addr, we, wdata and be for that port on that edge.
REQ-008 Round-robin: the search SHALL start at last_grant+1 modulo N_PORTS; last_grant SHALL update on each transfer.
REQ-009 ACCESS: the block SHALL drive SRAM_ADDR from the latched address and hold CE_N=0 and the byte lanes from be; a write SHALL set WE_N=0, OE_N=1 and drive DQ with the latched data; a read SHALL set OE_N=0, WE_N=1 and leave DQ hi-Z.
REQ-010 All SRAM outputs SHALL be registered, glitch-free and change only on CLOCK_50.
REQ-011 At the end of ACCESS, a read SHALL capture SRAM_DQ into rsp_rdata, and rsp_valid[owner] SHALL be high for one cycle during RECOVER.
REQ-012 Read latency SHALL be two cycles: transfer in cycle T, rsp_valid in T+2; throughput SHALL be one access per 3 cycles.
REQ-013 RECOVER SHALL set WE_N=1 and OE_N=1 while holding ADDR and DQ (write) stable, to meet SRAM hold time; DQ SHALL go hi-Z in IDLE.
REQ-014 Writes SHALL produce no response; rsp_rdata SHALL hold its last value until the next read capture.
REQ-015 A request with all-zero be SHALL still be granted and consume the slot, with the byte lanes deasserted and no SRAM write effect.
REQ-016 If req_valid drops before ready, nothing SHALL be granted and the pointer SHALL be unchanged.

Reset
REQ-017 While reset is high, state SHALL be IDLE, last_grant SHALL be N_PORTS-1 (port 0 wins first), req_ready=0, rsp_valid=0, rsp_rdata=0 and SRAM_ADDR=0; WE_N, OE_N, CE_N, UB_N and LB_N SHALL all be 1, and DQ SHALL be hi-Z.
REQ-018 A reset asserted mid-ACCESS or mid-RECOVER SHALL abort the access, deassert WE_N on the next edge and emit no rsp_valid.

Configuration
REQ-019 When macro SRAM_ARB_FIXED_PRIORITY_EN is defined, arbitration SHALL be fixed priority (lowest index wins) and last_grant SHALL be removed; when it is undefined, round-robin per REQ-008 SHALL apply.

Verification
REQ-020 The bench SHALL cover: reset release with port 0 write addr 0x00010 data 0xA5A5 be=11, then port 0 read 0x00010 -> rsp_valid[0] two cycles after the transfer, rsp_rdata=0xA5A5.
REQ-021 The bench SHALL cover: all 4 ports valid continuously -> grant order 0,1,2,3,0, one transfer every 3 cycles (round-robin build).
REQ-022 The bench SHALL cover: the same stimulus as REQ-021 with SRAM_ARB_FIXED_PRIORITY_EN -> port 0 granted every slot and ports 1-3 starved.
REQ-023 The bench SHALL cover: write 0xFFFF, then write 0x1234 with be=01, then read -> 0xFF34.
REQ-024 The bench SHALL cover: reset pulsed in the ACCESS cycle of a write -> WE_N=1 on the next edge, no rsp_valid, and port 0 granted first after release.
REQ-025 The bench SHALL cover: port 2 valid for a single IDLE cycle, then dropped -> transfer, and in the following IDLE port 3 wins over ports 0 and 1.
